pe_lin: RTL and testbench

- Linear (fully-connected) systolic processing element with four weight lanes.
- A streaming 8-bit activation enters a 3-deep delay chain; lane k multiplies its weight by the activation delayed k-1 cycles and accumulates the product.
- Sits in the linear-layer datapath. Upstream holds weights stable and streams activations qualified by fire; downstream reads the four accumulators.

---
 rtl/pe_lin_if.sv | 40 ++++
 rtl/pe_lin.sv | 98 +++++++++
 tb/tb_pe_lin.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pe_lin_if.sv
// ---------------------------------------------------------------------------
// pe_lin_if
//   Bus bundle for the pe_lin linear systolic processing element.
//
//   Signals:
//     fire    : advance enable (shift delay chain, accumulate all lanes)
//     w1..w4  : lane weights, unsigned, DATA_W bits
//     a       : streaming activation, unsigned, DATA_W bits
//     o1..o4  : lane accumulators, ACC_W bits
//
//   Modports:
//     master : upstream/downstream side (drives fire/weights/activation,
//              reads the accumulators)
//     slave  : the processing element itself
// ---------------------------------------------------------------------------
interface pe_lin_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
);
    logic              fire;
    logic [DATA_W-1:0] w1;
    logic [DATA_W-1:0] w2;
    logic [DATA_W-1:0] w3;
    logic [DATA_W-1:0] w4;
    logic [DATA_W-1:0] a;
    logic [ACC_W-1:0]  o1;
    logic [ACC_W-1:0]  o2;
    logic [ACC_W-1:0]  o3;
    logic [ACC_W-1:0]  o4;

    modport master (
        output fire, w1, w2, w3, w4, a,
        input  o1, o2, o3, o4
    );

    modport slave (
        input  fire, w1, w2, w3, w4, a,
        output o1, o2, o3, o4
    );
endinterface

// File: rtl/pe_lin.sv
// ---------------------------------------------------------------------------
// pe_lin
//   Linear (fully-connected) systolic processing element with four weight
//   lanes. The activation enters a 3-deep delay chain; lane k multiplies its
//   weight by the activation delayed k-1 firings and accumulates the product.
//   Every register advances only on a firing edge; with fire low the whole
//   element stalls in place.
//
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous, active-high reset (clears delay chain and
//           accumulators, has priority over fire)
//     bus : pe_lin_if.slave (fire, w1..w4, a in; o1..o4 out, registered)
//
//   Configuration macro:
//     PE_LIN_SATURATE_EN : when defined, each accumulator clamps at
//                          2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module pe_lin #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
) (
    input  logic     clk,
    input  logic     rst,
    pe_lin_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;
`ifdef PE_LIN_SATURATE_EN
    // One bit of headroom over the wider operand so the raw sum never wraps
    // before it is compared against the clamp value.
    localparam int SUM_W = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
`endif

    logic [DATA_W-1:0] a_d1_q, a_d2_q, a_d3_q;
    logic [DATA_W-1:0] a_d1_d, a_d2_d, a_d3_d;
    logic [ACC_W-1:0]  acc_q [4];
    logic [ACC_W-1:0]  acc_d [4];

    // Multiply-accumulate for one lane, with the overflow policy applied.
    function automatic logic [ACC_W-1:0] mac(
        input logic [ACC_W-1:0]  acc,
        input logic [DATA_W-1:0] w,
        input logic [DATA_W-1:0] x
    );
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(w) * PROD_W'(x);
`ifdef PE_LIN_SATURATE_EN
        begin
            logic [SUM_W-1:0] sum;
            sum = SUM_W'(acc) + SUM_W'(prod);
            // A saturated lane stays saturated: any further product is >= 0.
            if (sum > SUM_W'({ACC_W{1'b1}}))
                mac = {ACC_W{1'b1}};
            else
                mac = sum[ACC_W-1:0];
        end
`else
        mac = acc + ACC_W'(prod);
`endif
    endfunction

    always_comb begin
        a_d1_d = a_d1_q;
        a_d2_d = a_d2_q;
        a_d3_d = a_d3_q;
        for (int k = 0; k < 4; k++) acc_d[k] = acc_q[k];
        if (bus.fire) begin
            // All lanes use pre-edge chain contents, so lane k sees the
            // activation from k-1 firings ago.
            acc_d[0] = mac(acc_q[0], bus.w1, bus.a);
            acc_d[1] = mac(acc_q[1], bus.w2, a_d1_q);
            acc_d[2] = mac(acc_q[2], bus.w3, a_d2_q);
            acc_d[3] = mac(acc_q[3], bus.w4, a_d3_q);
            a_d1_d   = bus.a;
            a_d2_d   = a_d1_q;
            a_d3_d   = a_d2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_d1_q <= '0;
            a_d2_q <= '0;
            a_d3_q <= '0;
            for (int k = 0; k < 4; k++) acc_q[k] <= '0;
        end else begin
            a_d1_q <= a_d1_d;
            a_d2_q <= a_d2_d;
            a_d3_q <= a_d3_d;
            for (int k = 0; k < 4; k++) acc_q[k] <= acc_d[k];
        end
    end

    assign bus.o1 = acc_q[0];
    assign bus.o2 = acc_q[1];
    assign bus.o3 = acc_q[2];
    assign bus.o4 = acc_q[3];
endmodule

// File: tb/tb_pe_lin.sv
module tb_pe_lin;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 12;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_lin_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    pe_lin #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: list of every activation fired since reset (newest
    // first) and the four lane sums.
    int hist[$];
    int m[4];
    int wv[4];

    function automatic int add_policy(int cur, int add);
`ifdef PE_LIN_SATURATE_EN
        return (cur + add > ACC_MAX) ? ACC_MAX : cur + add;
`else
        return (cur + add) % (ACC_MAX + 1);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_of(int k);
        case (k)
            0: return 32'(bus.o1);
            1: return 32'(bus.o2);
            2: return 32'(bus.o3);
            default: return 32'(bus.o4);
        endcase
    endfunction

    task automatic check_model(input string tag);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_o%0d", tag, k + 1), out_of(k), 32'(m[k]));
    endtask

    task automatic check_const(input string tag, input int e1, input int e2, input int e3, input int e4);
        chk({tag, "_o1"}, out_of(0), 32'(e1));
        chk({tag, "_o2"}, out_of(1), 32'(e2));
        chk({tag, "_o3"}, out_of(2), 32'(e3));
        chk({tag, "_o4"}, out_of(3), 32'(e4));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input string tag, input bit r, input bit f, input int av);
        int x;
        rst      = r;
        bus.fire = f;
        bus.a    = DATA_W'(av);
        bus.w1   = DATA_W'(wv[0]);
        bus.w2   = DATA_W'(wv[1]);
        bus.w3   = DATA_W'(wv[2]);
        bus.w4   = DATA_W'(wv[3]);
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
            for (int k = 0; k < 4; k++) m[k] = 0;
        end else if (f) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0)            x = av;
                else if (hist.size() >= k) x = hist[k - 1];
                else                   x = 0;
                m[k] = add_policy(m[k], wv[k] * x);
            end
            hist.push_front(av);
        end
        check_model(tag);
    endtask

    task automatic set_w(input int a1, input int a2, input int a3, input int a4);
        wv[0] = a1; wv[1] = a2; wv[2] = a3; wv[3] = a4;
    endtask

    initial begin
        bus.fire = 1'b0;
        bus.a    = '0;
        set_w(1, 2, 3, 4);
        for (int k = 0; k < 4; k++) m[k] = 0;

        // Reset held with fire high and a nonzero activation.
        step("rst0", 1'b1, 1'b1, 9);
        step("rst1", 1'b1, 1'b1, 9);
        check_const("rst_const", 0, 0, 0, 0);
        step("rst_first", 1'b0, 1'b1, 0);
        check_const("rst_empty", 0, 0, 0, 0);

        // Single pulse travelling down the chain.
        step("pulse_a1", 1'b0, 1'b1, 1);
        check_const("pulse_e1", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("pulse_a0", 1'b0, 1'b1, 0);
        check_const("pulse_e4", 1, 2, 3, 4);

        // Unstalled stream 1..8.
        step("strm_rst", 1'b1, 1'b0, 0);
        for (int i = 1; i <= 8; i++) step("strm", 1'b0, 1'b1, i);
        check_const("strm_final", 36, 56, 63, 60);

        // Same stream with a 5-cycle stall after the 4th firing edge.
        step("stall_rst", 1'b1, 1'b0, 0);
        for (int i = 1; i <= 4; i++) step("stall_pre", 1'b0, 1'b1, i);
        for (int i = 0; i < 5; i++) begin
            step("stall_hold", 1'b0, 1'b0, int'($urandom_range(0, 255)));
            check_const("stall_frozen", 10, 12, 9, 4);
        end
        for (int i = 5; i <= 8; i++) step("stall_post", 1'b0, 1'b1, i);
        check_const("stall_final", 36, 56, 63, 60);

        // Overflow on lane 1.
        step("ovf_rst", 1'b1, 1'b0, 0);
        set_w(255, 0, 0, 0);
        step("ovf1", 1'b0, 1'b1, 255);
`ifdef PE_LIN_SATURATE_EN
        chk("ovf1_const", 32'(bus.o1), 32'd4095);
`else
        chk("ovf1_const", 32'(bus.o1), 32'd3585);
`endif
        step("ovf2", 1'b0, 1'b1, 255);
`ifdef PE_LIN_SATURATE_EN
        chk("ovf2_const", 32'(bus.o1), 32'd4095);
`else
        chk("ovf2_const", 32'(bus.o1), 32'd3074);
`endif

        // Reset in the middle of a stream, then a fresh stream.
        set_w(1, 2, 3, 4);
        step("mid_rst0", 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) step("mid_pre", 1'b0, 1'b1, int'($urandom_range(1, 255)));
        step("mid_rst", 1'b1, 1'b1, 77);
        check_const("mid_clear", 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step("mid_strm", 1'b0, 1'b1, i);
        check_const("mid_final", 36, 56, 63, 60);

        // Randomized traffic with changing weights, stalls and rare resets.
        for (int i = 0; i < 300; i++) begin
            set_w(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            if (i % 60 == 0) set_w(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            step("rand", ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
